// File: rtl/ps2_keyboard_decoder.sv
// ps2_keyboard_decoder
//   Turns the byte stream from the PS/2 controller into complete scan-code
//   set 2 key events. Handles the E0 extended prefix, the F0 break prefix,
//   the 8-byte E1 Pause sequence and keyboard status bytes, tracks live
//   shift/ctrl/alt state and queues events in a show-ahead FIFO.
//
// Ports
//   CLOCK_50      system clock
//   reset_n       synchronous active-low reset
//   rx_data       byte from the PS/2 controller
//   rx_valid      one-cycle strobe, rx_data valid
//   event_code    scan code of the head event (0 when FIFO empty)
//   event_ext     head event had E0 prefix (or is Pause)
//   event_break   head event is a release
//   event_mods    {alt,ctrl,shift} captured with the head event
//   event_valid   FIFO non-empty
//   event_ready   consumer pops the head when high with event_valid
//   mods          live {alt,ctrl,shift}
//   kb_ack        pulse: FA received
//   kb_resend     pulse: FE received
//   kb_bat_ok     pulse: AA received
//   kb_error      pulse: 00, FF or FC received
//   overflow      sticky: an event was dropped because the FIFO was full
//   overflow_clr  clears overflow (a simultaneous drop wins)
module ps2_keyboard_decoder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] event_code,
  output logic       event_ext,
  output logic       event_break,
  output logic [2:0] event_mods,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [2:0] mods,
  output logic       kb_ack,
  output logic       kb_resend,
  output logic       kb_bat_ok,
  output logic       kb_error,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    pcnt, pcnt_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;

  logic lshift, rshift, lctrl, rctrl, lalt, ralt;
  logic lshift_nxt, rshift_nxt, lctrl_nxt, rctrl_nxt, lalt_nxt, ralt_nxt;

  logic       emit;
  logic [7:0] em_code;
  logic       em_ext;
  logic       em_brk;
  logic       ack_nxt, resend_nxt, bat_nxt, err_nxt;
  logic [2:0] mods_nxt;

  // FIFO storage: {code[12:5], ext[4], brk[3], mods[2:0]}
  logic [12:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop, push_ok, drop;
  logic [12:0]   entry_p0;
  logic [12:0]   head;

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == 8'h12) || (b == 8'h59);
  endfunction

  // ---- stage 0: byte decode, modifier update, FIFO entry formation ----
  always_comb begin
    state_nxt  = state;
    pcnt_nxt   = pcnt;
    tcnt_nxt   = tcnt;
    emit       = 1'b0;
    em_code    = rx_data;
    em_ext     = 1'b0;
    em_brk     = 1'b0;
    ack_nxt    = 1'b0;
    resend_nxt = 1'b0;
    bat_nxt    = 1'b0;
    err_nxt    = 1'b0;

    // Timeout only runs while a multi-byte sequence is pending and silent.
    if (rx_valid || state == S_IDLE) begin
      tcnt_nxt = '0;
    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      tcnt_nxt  = '0;
      state_nxt = S_IDLE;
    end else begin
      tcnt_nxt = tcnt + TW'(1);
    end

    if (rx_valid) begin
      unique case (state)
        S_IDLE: begin
          unique case (rx_data)
            8'hE0: state_nxt = S_EXT;
            8'hF0: state_nxt = S_BRK;
            8'hE1: begin
              state_nxt = S_PAUSE;
              pcnt_nxt  = 3'd0;
            end
            8'hFA: ack_nxt    = 1'b1;
            8'hFE: resend_nxt = 1'b1;
            8'hAA: bat_nxt    = 1'b1;
            8'h00, 8'hFF, 8'hFC: err_nxt = 1'b1;
            default: emit = 1'b1;
          endcase
        end
        S_EXT: begin
          state_nxt = S_IDLE;
          if (rx_data == 8'hF0) begin
            state_nxt = S_EXT_BRK;
          end else if (!is_fake_shift(rx_data)) begin
            emit   = 1'b1;
            em_ext = 1'b1;
          end
        end
        S_BRK: begin
          state_nxt = S_IDLE;
          emit      = 1'b1;
          em_brk    = 1'b1;
        end
        S_EXT_BRK: begin
          state_nxt = S_IDLE;
          if (!is_fake_shift(rx_data)) begin
            emit   = 1'b1;
            em_ext = 1'b1;
            em_brk = 1'b1;
          end
        end
        S_PAUSE: begin
          // Content of the Pause sequence is fixed, so only its length matters.
          if (pcnt == 3'd6) begin
            state_nxt = S_IDLE;
            pcnt_nxt  = 3'd0;
            emit      = 1'b1;
            em_code   = 8'h77;
            em_ext    = 1'b1;
          end else begin
            pcnt_nxt = pcnt + 3'd1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lshift_nxt = lshift;
    rshift_nxt = rshift;
    lctrl_nxt  = lctrl;
    rctrl_nxt  = rctrl;
    lalt_nxt   = lalt;
    ralt_nxt   = ralt;
    if (emit) begin
      unique case ({em_ext, em_code})
        {1'b0, 8'h12}: lshift_nxt = !em_brk;
        {1'b0, 8'h59}: rshift_nxt = !em_brk;
        {1'b0, 8'h14}: lctrl_nxt  = !em_brk;
        {1'b1, 8'h14}: rctrl_nxt  = !em_brk;
        {1'b0, 8'h11}: lalt_nxt   = !em_brk;
        {1'b1, 8'h11}: ralt_nxt   = !em_brk;
        default: ;
      endcase
    end
    mods_nxt = {lalt_nxt | ralt_nxt, lctrl_nxt | rctrl_nxt, lshift_nxt | rshift_nxt};
  end

  // The entry carries the modifier state including this byte's own update.
  assign entry_p0 = {em_code, em_ext, em_brk, mods_nxt};

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = event_valid && event_ready;
  assign push    = emit;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  // ---- stage 1: registered control, modifiers, pulses and FIFO pointers ----
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pcnt      <= 3'd0;
      tcnt      <= '0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      lalt      <= 1'b0;
      ralt      <= 1'b0;
      kb_ack    <= 1'b0;
      kb_resend <= 1'b0;
      kb_bat_ok <= 1'b0;
      kb_error  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pcnt      <= pcnt_nxt;
      tcnt      <= tcnt_nxt;
      lshift    <= lshift_nxt;
      rshift    <= rshift_nxt;
      lctrl     <= lctrl_nxt;
      rctrl     <= rctrl_nxt;
      lalt      <= lalt_nxt;
      ralt      <= ralt_nxt;
      kb_ack    <= ack_nxt;
      kb_resend <= resend_nxt;
      kb_bat_ok <= bat_nxt;
      kb_error  <= err_nxt;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem[wr_ptr] <= entry_p0;
  end

  assign head        = mem[rd_ptr];
  assign event_valid = (count != '0);
  assign event_code  = event_valid ? head[12:5] : 8'h00;
  assign event_ext   = event_valid & head[4];
  assign event_break = event_valid & head[3];
  assign event_mods  = event_valid ? head[2:0] : 3'b000;
  assign mods        = {lalt | ralt, lctrl | rctrl, lshift | rshift};

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
module tb_ps2_keyboard_decoder;

  localparam int DEPTH = 8;
  localparam int TMO   = 40;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] event_code;
  logic       event_ext;
  logic       event_break;
  logic [2:0] event_mods;
  logic       event_valid;
  logic       event_ready  = 1'b1;
  logic [2:0] mods;
  logic       kb_ack, kb_resend, kb_bat_ok, kb_error;
  logic       overflow;
  logic       overflow_clr = 1'b0;

  ps2_keyboard_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .event_code  (event_code),
    .event_ext   (event_ext),
    .event_break (event_break),
    .event_mods  (event_mods),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .mods        (mods),
    .kb_ack      (kb_ack),
    .kb_resend   (kb_resend),
    .kb_bat_ok   (kb_bat_ok),
    .kb_error    (kb_error),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;
  logic [12:0] exp_q[$];   // {code, ext, brk, mods}
  logic [3:0]  pls_q[$];   // {ack, resend, bat_ok, error}

  function automatic logic [12:0] ev(input logic [7:0] c, input logic e, input logic b,
                                     input logic [2:0] m);
    return {c, e, b, m};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic monitor();
    logic [12:0] got, want;
    logic [3:0]  p;
    forever begin
      @(negedge CLOCK_50);
      if (event_valid && event_ready) begin
        got = {event_code, event_ext, event_break, event_mods};
        if (exp_q.size() == 0) begin
          check("unexpected_event", {19'd0, got}, 32'hFFFF_FFFF);
        end else begin
          want = exp_q.pop_front();
          check("event", {19'd0, got}, {19'd0, want});
        end
      end
      p = {kb_ack, kb_resend, kb_bat_ok, kb_error};
      if (p != 4'b0000) begin
        if (pls_q.size() == 0) check("unexpected_pulse", {28'd0, p}, 32'd0);
        else check("pulse", {28'd0, p}, {28'd0, pls_q.pop_front()});
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLOCK_50);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && pls_q.size() == 0) break;
      @(posedge CLOCK_50);
    end
    #1;
    check({name, "_drained"}, exp_q.size() + pls_q.size(), 0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    idle(3);
    #1 reset_n = 1'b1;
    // reset state
    check("rst_valid", event_valid, 0);
    check("rst_code", event_code, 0);
    check("rst_mods", mods, 0);
    check("rst_overflow", overflow, 0);
    check("rst_pulses", {kb_ack, kb_resend, kb_bat_ok, kb_error}, 0);

    // basic make / break, latency of one cycle
    exp_q.push_back(ev(8'h1C, 0, 0, 3'b000));
    send(8'h1C);
    check("lat_make", event_valid, 1);
    exp_q.push_back(ev(8'h1C, 0, 1, 3'b000));
    send(8'hF0);
    check("no_event_on_prefix", event_valid, 0);
    send(8'h1C);
    check("lat_break", event_valid, 1);
    drain("basic");

    // extended codes and modifiers
    exp_q.push_back(ev(8'h12, 0, 0, 3'b001));
    send(8'h12);
    check("mods_shift_live", mods, 3'b001);
    exp_q.push_back(ev(8'h14, 1, 0, 3'b011));
    send(8'hE0); send(8'h14);
    exp_q.push_back(ev(8'h1C, 0, 0, 3'b011));
    send(8'h1C);
    exp_q.push_back(ev(8'h14, 1, 1, 3'b001));
    send(8'hE0); send(8'hF0); send(8'h14);
    exp_q.push_back(ev(8'h12, 0, 1, 3'b000));
    send(8'hF0); send(8'h12);
    drain("mods");
    check("mods_final", mods, 3'b000);

    // left alt make then right alt break leaves alt set
    exp_q.push_back(ev(8'h11, 0, 0, 3'b100));
    send(8'h11);
    exp_q.push_back(ev(8'h11, 1, 1, 3'b100));
    send(8'hE0); send(8'hF0); send(8'h11);
    exp_q.push_back(ev(8'h11, 0, 1, 3'b000));
    send(8'hF0); send(8'h11);
    drain("alt");

    // fake shifts and Pause
    send(8'hE0); send(8'h12);
    send(8'hE0); send(8'hF0); send(8'h12);
    idle(2);
    check("fake_shift_mods", mods, 0);
    check("fake_shift_noev", event_valid, 0);
    exp_q.push_back(ev(8'h77, 1, 0, 3'b000));
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    exp_q.push_back(ev(8'h1C, 0, 0, 3'b000));
    send(8'h1C);
    drain("pause");

    // status bytes
    pls_q.push_back(4'b1000); send(8'hFA); idle(1);
    pls_q.push_back(4'b0100); send(8'hFE); idle(1);
    pls_q.push_back(4'b0010); send(8'hAA); idle(1);
    pls_q.push_back(4'b0001); send(8'hFF); idle(1);
    pls_q.push_back(4'b0001); send(8'h00); idle(1);
    exp_q.push_back(ev(8'hFA, 0, 1, 3'b000));
    send(8'hF0); send(8'hFA);
    drain("status");

    // FIFO fill and overflow
    event_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) exp_q.push_back(ev(8'h20 + 8'(i), 0, 0, 3'b000));
      send(8'h20 + 8'(i));
    end
    check("ovf_set", overflow, 1);
    check("full_valid", event_valid, 1);
    check("full_head", event_code, 8'h20);
    overflow_clr = 1'b1; idle(1); overflow_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    // push and pop together while full
    event_ready = 1'b1;
    exp_q.push_back(ev(8'h30, 0, 0, 3'b000));
    send(8'h30);
    event_ready = 1'b0;
    check("full_pushpop_no_ovf", overflow, 0);
    check("full_pushpop_head", event_code, 8'h21);
    // drop while clear is asserted: set wins
    overflow_clr = 1'b1;
    send(8'h31);
    overflow_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    overflow_clr = 1'b1; idle(1); overflow_clr = 1'b0;
    check("ovf_clr2", overflow, 0);
    event_ready = 1'b1;
    drain("fifo");
    check("fifo_empty", event_valid, 0);

    // timeout: short gap keeps the prefix, long gap abandons it
    exp_q.push_back(ev(8'h1C, 1, 0, 3'b000));
    send(8'hE0); idle(10); send(8'h1C);
    exp_q.push_back(ev(8'h1C, 0, 0, 3'b000));
    send(8'hE0); idle(TMO + 5); send(8'h1C);
    drain("timeout");

    // reset mid-sequence with a modifier held
    exp_q.push_back(ev(8'h12, 0, 0, 3'b001));
    send(8'h12);
    drain("pre_reset");
    send(8'hE0);
    reset_n = 1'b0; idle(1); reset_n = 1'b1;
    check("rst_mid_valid", event_valid, 0);
    check("rst_mid_mods", mods, 0);
    exp_q.push_back(ev(8'h1C, 0, 0, 3'b000));
    send(8'h1C);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_decoder.md
Name: ps2_keyboard_decoder

Overview:
- Sits directly downstream of the PS/2 controller. Consumes its received byte stream (`received_data` / `received_data_en`).
- Decodes PS/2 scan-code set 2 framing: the E0 extended prefix, the F0 break prefix, the E1 Pause sequence and keyboard status bytes.
- Produces complete key events, each tagged with modifier state, through a small show-ahead FIFO with a valid/ready handshake to the CPU-side consumer.
- Tracks live shift/ctrl/alt state.

Parameters:
- FIFO_DEPTH, 8, number of queued events; power of two, 2..64.
- TIMEOUT_CYCLES, 1_000_000, idle CLOCK_50 cycles after which a partial multi-byte sequence is abandoned (20 ms).

Ports:
- CLOCK_50  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- rx_data  in  8  byte from PS/2 controller
- rx_valid  in  1  one-cycle strobe, rx_data valid
- event_code  out  8  scan code of head event
- event_ext  out  1  head event had E0 prefix (or is Pause)
- event_break  out  1  head event is a release
- event_mods  out  3  {alt,ctrl,shift} snapshot at head event
- event_valid  out  1  FIFO non-empty
- event_ready  in  1  consumer pops head when high with event_valid
- mods  out  3  live {alt,ctrl,shift}
- kb_ack  out  1  pulse: FA received
- kb_resend  out  1  pulse: FE received
- kb_bat_ok  out  1  pulse: AA received
- kb_error  out  1  pulse: 00, FF or FC received
- overflow  out  1  sticky: event dropped, FIFO full
- overflow_clr  in  1  clears overflow

Behaviour:
- Clock and reset: one clock, CLOCK_50. reset_n is synchronous, active-low.
- Reset (reset_n=0 at edge):
  - state=IDLE; FIFO emptied.
  - mods=0, overflow=0, all pulses 0, timeout counter 0.
  - event_valid=0; event_* fields 0.
- Bytes are processed only on cycles with rx_valid=1. All decisions are made on that cycle's edge.
- State transitions:
  - IDLE:
    - E0 -> EXT; F0 -> BRK; E1 -> PAUSE with pcnt=0.
    - FA/FE/AA: pulse kb_ack / kb_resend / kb_bat_ok; stay in IDLE.
    - 00/FF/FC: pulse kb_error; stay in IDLE.
    - Any other byte: emit (code, ext=0, brk=0).
  - EXT:
    - F0 -> EXT_BRK.
    - 12 or 59 (fake shift): discard, go to IDLE.
    - Else: emit (code, 1, 0), go to IDLE.
  - BRK: emit (code, 0, 1), go to IDLE.
  - EXT_BRK:
    - 12 or 59: discard, go to IDLE.
    - Else: emit (code, 1, 1), go to IDLE.
  - PAUSE:
    - pcnt increments per byte; byte values are not checked.
    - On the 7th byte after E1: emit (77, ext=1, brk=0), go to IDLE.
- Status bytes are recognised only in IDLE. In any other state they are treated as codes.
- Modifier tracking, applied on the emit cycle:
  - shift = lshift(12) | rshift(59), non-extended only.
  - ctrl = L(14) | R(E0 14).
  - alt = L(11) | R(E0 11).
  - Make sets the bit; break clears it. Left and right are tracked independently internally.
  - The FIFO entry captures mods after this byte's update (a shift make event carries shift=1).
  - The live `mods` output updates the cycle after the byte.
- Latency: rx_valid at edge N. The event is written at edge N, so event_valid=1 in cycle N+1 if the FIFO was empty.
- Pulse outputs are high for exactly cycle N+1.
- FIFO:
  - Entries are 13 bits.
  - Pop occurs when event_valid & event_ready; the head advances the next cycle.
  - Push with FIFO full and no pop in the same cycle: the event is dropped, overflow=1, FIFO unchanged.
  - Full, pop and push in the same cycle: both accepted, count unchanged, no overflow.
  - Empty, push and ready in the same cycle: no pop (event_valid was 0).
- overflow: overflow_clr clears it. If a set and a clear occur in the same cycle, the set wins.
- Timeout:
  - The counter resets on every rx_valid and is held at 0 in IDLE.
  - In a non-IDLE state, reaching TIMEOUT_CYCLES returns the FSM to IDLE with no emit. mods are unchanged.
- Reset mid-sequence, e.g. after E0: reset returns to IDLE. The next byte is decoded as non-extended.

Test Plan:
- Basic make/break: bytes 1C, F0 1C with ready=1 -> two events (1C,0,0,mods=0) then (1C,0,1,0); event_valid rises 1 cycle after each byte.
- Extended and modifiers: 12, E0 14, 1C, E0 F0 14, F0 12 -> five events: (12,0,0,001), (14,1,0,011), (1C,0,0,011), (14,1,1,001), (12,0,1,000); final mods=000.
- Fake shifts and Pause: E0 12, E0 F0 12 -> no events, mods=0. Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event (77,1,0). A following 1C decodes normally.
- Status bytes: FA, FE, AA, FF each in IDLE -> one-cycle kb_ack, kb_resend, kb_bat_ok, kb_error, no events. F0 FA -> event (FA,0,1), no pulse.
- FIFO and overflow: ready=0, FIFO_DEPTH+1 make codes -> FIFO holds the first 8, overflow=1. Drain with ready=1 -> codes in order. At full, push and pop in the same cycle -> no overflow. overflow_clr -> 0.
- Timeout and reset: E0, then silence TIMEOUT_CYCLES, then 1C -> event (1C,0,0). E0, then reset_n=0 for 1 cycle, then 1C -> (1C,0,0), FIFO empty before it.
